bpred_ctrl: RTL and testbench

Branch-prediction bookkeeping and recovery controller for the pipelined datapath. Records every prediction made by the fetch-stage 2-bit predictor in an in-order queue and checks each against the branch outcome resolved in MEM. On a mispredict it issues a one-cycle flush with the corrected PC. For every resolved branch it issues a predictor-table training update.

---
 rtl/bpred_ctrl_if.sv | 38 +++
 rtl/bpred_ctrl.sv | 136 +++++++++++++
 tb/tb_bpred_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bpred_ctrl_if.sv
// Fetch/MEM-side bundle for the branch-prediction controller: prediction push,
// branch resolution, queue status, flush/redirect and predictor training.
interface bpred_ctrl_if #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              push;
  logic [31:0]       push_pc;
  logic              push_taken;
  logic [31:0]       push_target;
  logic              resolve;
  logic              res_taken;
  logic [31:0]       res_target;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              flush;
  logic [31:0]       redirect_pc;
  logic              upd_en;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_taken;
  logic [15:0]       mispred_cnt;
  logic              err;

  modport master (
    output push, push_pc, push_taken, push_target, resolve, res_taken, res_target,
    input  full, empty, count, flush, redirect_pc, upd_en, upd_idx, upd_taken,
           mispred_cnt, err
  );

  modport slave (
    input  push, push_pc, push_taken, push_target, resolve, res_taken, res_target,
    output full, empty, count, flush, redirect_pc, upd_en, upd_idx, upd_taken,
           mispred_cnt, err
  );
endinterface

// File: rtl/bpred_ctrl.sv
// Branch-prediction bookkeeping: in-order queue of fetch predictions, checked
// against MEM resolutions; issues flush/redirect on mispredict and table training.
module bpred_ctrl #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  bpred_ctrl_if.slave bp
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_flush;
  logic [31:0]      r_redirect;
  logic             r_upd_en;
  logic [IDX_W-1:0] r_upd_idx;
  logic             r_upd_taken;
  logic [15:0]      r_mis_cnt;
  logic             r_err;

  logic [31:0]      r_q_pc  [DEPTH];
  logic             r_q_tk  [DEPTH];
  logic [31:0]      r_q_tgt [DEPTH];

  logic             w_res_ok;
  logic             w_mis;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_err_set;
  logic [31:0]      w_head_pc;
  logic             w_head_tk;
  logic [31:0]      w_head_tgt;
  logic [31:0]      w_redirect;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_head_pc  = r_q_pc[r_rd_ptr];
  assign w_head_tk  = r_q_tk[r_rd_ptr];
  assign w_head_tgt = r_q_tgt[r_rd_ptr];
  assign w_redirect = bp.res_taken ? bp.res_target : w_head_pc + 32'd4;

  // Mispredict outranks everything: it clears the queue and discards a same-cycle push.
  always_comb begin
    w_state_nxt = r_state;
    w_res_ok    = 1'b0;
    w_mis       = 1'b0;
    w_pop       = 1'b0;
    w_push_ok   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      RUN: begin
        w_res_ok  = bp.resolve && !r_empty;
        w_mis     = w_res_ok && ((w_head_tk != bp.res_taken) ||
                                 (bp.res_taken && (w_head_tgt != bp.res_target)));
        w_pop     = w_res_ok && !w_mis;
        w_push_ok = bp.push && !w_mis && (!r_full || w_pop);
        w_err_set = (bp.push && r_full && !bp.resolve) || (bp.resolve && r_empty);
        if (w_mis) w_state_nxt = RECOVER;
      end
      RECOVER: w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_count_nxt = w_mis ? '0 : r_count + CW'(w_push_ok) - CW'(w_pop);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_flush     <= 1'b0;
      r_redirect  <= '0;
      r_upd_en    <= 1'b0;
      r_upd_idx   <= '0;
      r_upd_taken <= 1'b0;
      r_mis_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
      r_flush  <= w_mis;
      r_upd_en <= w_res_ok;
      if (w_mis) r_rd_ptr <= r_wr_ptr;
      else if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_mis) begin
        r_redirect <= w_redirect;
        r_mis_cnt  <= sat_inc16(r_mis_cnt);
      end
      if (w_res_ok) begin
        r_upd_idx   <= w_head_pc[IDX_W+1:2];
        r_upd_taken <= bp.res_taken;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Queue payload carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_q_pc[r_wr_ptr]  <= bp.push_pc;
      r_q_tk[r_wr_ptr]  <= bp.push_taken;
      r_q_tgt[r_wr_ptr] <= bp.push_target;
    end
  end

  assign bp.full        = r_full;
  assign bp.empty       = r_empty;
  assign bp.count       = r_count;
  assign bp.flush       = r_flush;
  assign bp.redirect_pc = r_redirect;
  assign bp.upd_en      = r_upd_en;
  assign bp.upd_idx     = r_upd_idx;
  assign bp.upd_taken   = r_upd_taken;
  assign bp.mispred_cnt = r_mis_cnt;
  assign bp.err         = r_err;
endmodule

// File: tb/tb_bpred_ctrl.sv
// Bench for bpred_ctrl: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and a randomized traffic phase.
module tb_bpred_ctrl;
  localparam int DEPTH = 4;
  localparam int IDX_W = 4;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  bpred_ctrl_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bp();
  bpred_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (.CLK(CLK), .nRST(nRST), .bp(bp));

  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;

  ent_t             mq[$];
  bit               m_recov;
  bit               m_err;
  int               m_mcnt;
  bit               e_flush;
  bit               e_upd_en;
  bit               e_upd_tk;
  logic [31:0]      e_redir;
  logic [IDX_W-1:0] e_upd_idx;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one step per clock edge, straight from the queue rules.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mq.delete();
      m_recov = 0; m_err = 0; m_mcnt = 0;
      e_flush = 0; e_upd_en = 0; e_upd_tk = 0; e_redir = '0; e_upd_idx = '0;
    end else begin
      bit   mis;
      ent_t h;
      mis = 0;
      e_flush = 0;
      e_upd_en = 0;
      if (m_recov) begin
        m_recov = 0;
      end else begin
        if (bp.resolve) begin
          if (mq.size() == 0) m_err = 1;
          else begin
            h = mq[0];
            e_upd_en  = 1;
            e_upd_idx = h.pc[IDX_W+1:2];
            e_upd_tk  = bp.res_taken;
            mis = (h.tk != bp.res_taken) || (bp.res_taken && (h.tgt != bp.res_target));
            if (mis) begin
              mq.delete();
              e_flush = 1;
              e_redir = bp.res_taken ? bp.res_target : h.pc + 32'd4;
              if (m_mcnt < 65535) m_mcnt++;
              m_recov = 1;
            end else begin
              void'(mq.pop_front());
            end
          end
        end
        if (bp.push && !mis) begin
          if (mq.size() < DEPTH) mq.push_back('{bp.push_pc, bp.push_taken, bp.push_target});
          else m_err = 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    chk("count", 32'(bp.count), 32'(mq.size()));
    chk("full", 32'(bp.full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(bp.empty), 32'(mq.size() == 0));
    chk("flush", 32'(bp.flush), 32'(e_flush));
    chk("upd_en", 32'(bp.upd_en), 32'(e_upd_en));
    chk("err", 32'(bp.err), 32'(m_err));
    chk("mispred_cnt", 32'(bp.mispred_cnt), 32'(m_mcnt));
    if (e_flush) chk("redirect_pc", bp.redirect_pc, e_redir);
    if (e_upd_en) begin
      chk("upd_idx", 32'(bp.upd_idx), 32'(e_upd_idx));
      chk("upd_taken", 32'(bp.upd_taken), 32'(e_upd_tk));
    end
  end

  task automatic drive(input bit p, input logic [31:0] ppc, input bit ptk, input logic [31:0] ptg,
                       input bit r, input bit rtk, input logic [31:0] rtg);
    bp.push = p; bp.push_pc = ppc; bp.push_taken = ptk; bp.push_target = ptg;
    bp.resolve = r; bp.res_taken = rtk; bp.res_target = rtg;
    @(negedge CLK);
  endtask

  task automatic idle();
    drive(0, '0, 0, '0, 0, 0, '0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_full"}, 32'(bp.full), 0);
    chk({tag, "_empty"}, 32'(bp.empty), 1);
    chk({tag, "_count"}, 32'(bp.count), 0);
    chk({tag, "_flush"}, 32'(bp.flush), 0);
    chk({tag, "_redirect"}, bp.redirect_pc, 0);
    chk({tag, "_upd_en"}, 32'(bp.upd_en), 0);
    chk({tag, "_upd_idx"}, 32'(bp.upd_idx), 0);
    chk({tag, "_upd_taken"}, 32'(bp.upd_taken), 0);
    chk({tag, "_mcnt"}, 32'(bp.mispred_cnt), 0);
    chk({tag, "_err"}, 32'(bp.err), 0);
  endtask

  initial begin
    logic [31:0] pool [3];
    pool[0] = 32'h40; pool[1] = 32'h80; pool[2] = 32'hC0;
    bp.push = 0; bp.push_pc = '0; bp.push_taken = 0; bp.push_target = '0;
    bp.resolve = 0; bp.res_taken = 0; bp.res_target = '0;
    repeat (2) @(negedge CLK);
    chk_reset_vals("rst0");
    nRST = 1'b1;

    // correct path
    drive(1, 32'h100, 0, 0, 0, 0, 0);        chk("cp_cnt1", 32'(bp.count), 1);
    drive(1, 32'h200, 1, 32'h40, 0, 0, 0);   chk("cp_cnt2", 32'(bp.count), 2);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("cp_cnt3", 32'(bp.count), 1); chk("cp_upd1", 32'(bp.upd_en), 1);
    chk("cp_idx1", 32'(bp.upd_idx), 0); chk("cp_tk1", 32'(bp.upd_taken), 0);
    chk("cp_fl1", 32'(bp.flush), 0);
    drive(0, 0, 0, 0, 1, 1, 32'h40);
    chk("cp_cnt4", 32'(bp.count), 0); chk("cp_upd2", 32'(bp.upd_en), 1);
    chk("cp_idx2", 32'(bp.upd_idx), 0); chk("cp_tk2", 32'(bp.upd_taken), 1);
    chk("cp_fl2", 32'(bp.flush), 0);
    idle();
    chk("cp_upd_off", 32'(bp.upd_en), 0);

    // direction mispredict with a same-cycle push, then a wrong-path cycle
    drive(1, 32'h104, 0, 0, 0, 0, 0);
    drive(1, 32'h108, 0, 0, 0, 0, 0);
    drive(1, 32'h10C, 0, 0, 1, 1, 32'h80);
    chk("dm_flush", 32'(bp.flush), 1); chk("dm_redir", bp.redirect_pc, 32'h80);
    chk("dm_idx", 32'(bp.upd_idx), 1); chk("dm_tk", 32'(bp.upd_taken), 1);
    chk("dm_mcnt", 32'(bp.mispred_cnt), 1); chk("dm_cnt", 32'(bp.count), 0);
    drive(1, 32'h110, 0, 0, 1, 0, 0);
    chk("dm_rec_fl", 32'(bp.flush), 0); chk("dm_rec_upd", 32'(bp.upd_en), 0);
    chk("dm_rec_cnt", 32'(bp.count), 0); chk("dm_rec_err", 32'(bp.err), 0);

    // target mispredict, then not-taken redirect
    drive(1, 32'h500, 1, 32'h300, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h304);
    chk("tm_flush", 32'(bp.flush), 1); chk("tm_redir", bp.redirect_pc, 32'h304);
    chk("tm_mcnt", 32'(bp.mispred_cnt), 2);
    idle();
    drive(1, 32'h3FC, 1, 32'h10, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("nt_flush", 32'(bp.flush), 1); chk("nt_redir", bp.redirect_pc, 32'h400);
    chk("nt_idx", 32'(bp.upd_idx), 15); chk("nt_mcnt", 32'(bp.mispred_cnt), 3);
    idle();

    // fill, overflow, push+pop while full, drain in order
    for (int i = 0; i < 4; i++) drive(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0, 0);
    chk("ov_full", 32'(bp.full), 1); chk("ov_cnt4", 32'(bp.count), 4);
    drive(1, 32'h1014, 0, 0, 0, 0, 0);
    chk("ov_err", 32'(bp.err), 1); chk("ov_cnt_drop", 32'(bp.count), 4);
    drive(1, 32'h1010, 0, 0, 1, 0, 0);
    chk("ov_pp_cnt", 32'(bp.count), 4); chk("ov_pp_idx", 32'(bp.upd_idx), 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("ov_drain_idx", 32'(bp.upd_idx), 32'(i));
    end
    chk("ov_empty", 32'(bp.empty), 1);

    // wrap-around: 10 push/resolve pairs
    drive(1, 32'h2000, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      drive(1, 32'h2000 + 32'(4 * k), 0, 0, 1, 0, 0);
      chk("wr_idx", 32'(bp.upd_idx), 32'((k - 1) % 16));
      chk("wr_cnt", 32'(bp.count), 1);
    end
    drive(0, 0, 0, 0, 1, 0, 0);

    // asynchronous reset mid-traffic
    drive(1, 32'h700, 0, 0, 0, 0, 0);
    drive(1, 32'h704, 1, 32'h40, 0, 0, 0);
    bp.push = 0;
    #2 nRST = 1'b0;
    #1 chk_reset_vals("rst1");
    @(negedge CLK);
    nRST = 1'b1;

    // resolve against an empty queue
    drive(0, 0, 0, 0, 1, 1, 32'h40);
    chk("em_err", 32'(bp.err), 1); chk("em_upd", 32'(bp.upd_en), 0);
    chk("em_flush", 32'(bp.flush), 0); chk("em_cnt", 32'(bp.count), 0);
    idle();
    #2 nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit p, ptk, r, rtk;
      logic [31:0] ppc, ptg, rtg;
      p   = ($urandom % 2) == 1;
      ppc = 32'($urandom_range(0, 1023)) << 2;
      ptk = ($urandom % 2) == 1;
      ptg = pool[$urandom % 3];
      r   = (mq.size() > 0) ? ($urandom % 100 < 45) : ($urandom % 100 < 3);
      rtk = ($urandom % 2) == 1;
      rtg = pool[$urandom % 3];
      if (mq.size() == DEPTH && !r && ($urandom % 8 != 0)) p = 0;
      if (r && mq.size() > 0 && ($urandom % 4 != 0)) begin
        rtk = mq[0].tk;
        if (mq[0].tk) rtg = mq[0].tgt;
      end
      drive(p, ppc, ptk, ptg, r, rtk, rtg);
      if ($urandom % 500 == 0) begin
        bp.push = 0; bp.resolve = 0;
        #2 nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
      end
    end
    repeat (3) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
